// File: rtl/lfo_pkg.sv
// Shared types and constants for the LFO bank: wave shapes, config selectors
// and sweep FSM states.
package lfo_pkg;

  typedef enum logic [1:0] {
    SQUARE           = 2'b00,
    TRIANGLE         = 2'b01,
    SAWTOOTH         = 2'b10,
    REVERSE_SAWTOOTH = 2'b11
  } wave_e;

  localparam logic [1:0] CFG_FREQ = 2'd0;
  localparam logic [1:0] CFG_AMP  = 2'd1;
  localparam logic [1:0] CFG_WAVE = 2'd2;
  localparam logic [1:0] CFG_SYNC = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/lfo_shaper.sv
// Combinational wave shaper: maps the top bits of a phase word and a wave type
// to a signed full-scale sample in [-M, M-1], M = 2^(OUT_W-1).
module lfo_shaper
  import lfo_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic        [OUT_W-1:0] t,
  input  wave_e                   wave,
  output logic signed [OUT_W-1:0] raw
);

  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  logic [OUT_W-2:0] fold;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    raw  = '0;
    // Triangle folds the upper half of the phase back down.
    fold = t[OUT_W-1] ? ~t[OUT_W-2:0] : t[OUT_W-2:0];
    case (wave)
      SAWTOOTH:         raw = t - MID;
      REVERSE_SAWTOOTH: raw = ~(t - MID);
      SQUARE:           raw = t[OUT_W-1] ? MID : ~MID;
      TRIANGLE:         raw = {fold, 1'b0} - MID;
      default:          raw = '0;
    endcase
  end

endmodule

// File: rtl/lfo_bank.sv
// Time-multiplexed LFO bank: each tick sweeps all channels one per clock,
// advancing each phase accumulator and emitting an amplitude-scaled sample.
module lfo_bank
  import lfo_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int PHASE_W = 24,
  parameter  int FREQ_W  = 16,
  parameter  int OUT_W   = 8,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_tick,
  input  logic                    i_cfg_valid,
  output logic                    o_cfg_ready,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [1:0]              i_cfg_sel,
  input  logic [FREQ_W-1:0]       i_cfg_data,
  output logic                    o_valid,
  output logic [CH_W-1:0]         o_ch,
  output logic signed [OUT_W-1:0] o_sample,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam int              PROD_W  = 2 * OUT_W + 1;

  logic [PHASE_W-1:0] phase [N_CH];
  logic [FREQ_W-1:0]  freq  [N_CH];
  logic [OUT_W-1:0]   amp   [N_CH];
  wave_e              wave  [N_CH];

  state_e             state, state_nxt;
  logic [CH_W-1:0]    c;
  logic               start, cfg_we, last_ch;

  logic [PHASE_W-1:0]       phase_sum;
  logic [OUT_W-1:0]         t;
  logic signed [OUT_W-1:0]  raw;
  logic signed [PROD_W-1:0] raw_ext, amp_ext, product;
  logic signed [OUT_W-1:0]  sample_nxt;

  assign o_busy      = (state == SWEEP) || o_valid;
  assign o_cfg_ready = !o_busy;
  assign start       = i_tick && !o_busy;
  assign cfg_we      = i_cfg_valid && o_cfg_ready;
  assign last_ch     = (c == LAST_CH);

  // Stage 1: advance the selected channel and shape its new phase.
  assign phase_sum = phase[c] + PHASE_W'(freq[c]);
  assign t         = phase_sum[PHASE_W-1 -: OUT_W];

  lfo_shaper #(.OUT_W(OUT_W)) u_shaper (
    .t    (t),
    .wave (wave[c]),
    .raw  (raw)
  );

  // Amplitude is unsigned, so it enters the multiply with a zero sign bit.
  assign raw_ext    = PROD_W'(raw);
  assign amp_ext    = PROD_W'($signed({1'b0, amp[c]}));
  assign product    = raw_ext * amp_ext;
  assign sample_nxt = OUT_W'(product >>> OUT_W);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = SWEEP;
      SWEEP:   if (last_ch) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      c         <= '0;
      o_valid   <= 1'b0;
      o_ch      <= '0;
      o_sample  <= '0;
      o_overrun <= 1'b0;
      // NOTE: the channel arrays are reset too, since a reset must leave every channel silent and in phase.
      for (int i = 0; i < N_CH; i++) begin
        phase[i] <= '0;
        freq[i]  <= '0;
        amp[i]   <= '0;
        wave[i]  <= SQUARE;
      end
    end else begin
      o_valid <= 1'b0;
      if (i_tick && o_busy) o_overrun <= 1'b1;

      if (state == SWEEP) begin
        phase[c] <= phase_sum;
        o_valid  <= 1'b1;
        o_ch     <= c;
        o_sample <= sample_nxt;
        c        <= last_ch ? '0 : c + CH_W'(1);
      end else if (cfg_we) begin
        // Writes land only while idle, so they never collide with the sweep.
        case (i_cfg_sel)
          CFG_FREQ: freq[i_cfg_ch]  <= i_cfg_data;
          CFG_AMP:  amp[i_cfg_ch]   <= i_cfg_data[OUT_W-1:0];
          CFG_WAVE: wave[i_cfg_ch]  <= wave_e'(i_cfg_data[1:0]);
          default:  phase[i_cfg_ch] <= PHASE_W'(i_cfg_data) << (PHASE_W - FREQ_W);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfo_bank.sv
// Self-checking bench for lfo_bank: directed scenarios plus random traffic,
// all checked every cycle against a behavioural channel model.
`timescale 1ns/1ps
module tb_lfo_bank;
  import lfo_pkg::*;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_tick = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic [1:0]        i_cfg_ch = '0;
  logic [1:0]        i_cfg_sel = '0;
  logic [15:0]       i_cfg_data = '0;
  logic              o_cfg_ready, o_valid, o_busy, o_overrun;
  logic [1:0]        o_ch;
  logic signed [7:0] o_sample;

  lfo_bank dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_tick      (i_tick),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_sel   (i_cfg_sel),
    .i_cfg_data  (i_cfg_data),
    .o_valid     (o_valid),
    .o_ch        (o_ch),
    .o_sample    (o_sample),
    .o_busy      (o_busy),
    .o_overrun   (o_overrun)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; int ch; int sample; } exp_t;
  exp_t q[$];
  int   m_phase [N];
  int   m_freq  [N];
  int   m_amp   [N];
  int   m_wave  [N];
  bit   m_ovr = 1'b0;
  bit   m_bsy;
  int   last_tick = -1000;
  int   cyc = 0;
  bit   checking_en = 1'b0;
  int   got_sample [N];
  int   got_cnt = 0;

  function automatic int model_sample(input int wv, input int t, input int a);
    int raw;
    case (wv)
      0:       raw = (t < 128) ? 127 : -128;
      1:       raw = (t < 128) ? 2 * t - 128 : 2 * (255 - t) - 128;
      2:       raw = t - 128;
      default: raw = 127 - t;
    endcase
    return (raw * a) >>> 8;
  endfunction

  function automatic bit busy_at(input int n);
    return (n >= last_tick + 1) && (n <= last_tick + N + 1);
  endfunction

  always @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < N; i++) begin
        m_phase[i] = 0; m_freq[i] = 0; m_amp[i] = 0; m_wave[i] = 0;
      end
      m_ovr = 1'b0;
      last_tick = -1000;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    end else begin
      m_bsy = busy_at(cyc);
      if (i_cfg_valid && !m_bsy) begin
        case (i_cfg_sel)
          2'd0:    m_freq[i_cfg_ch]  = int'(i_cfg_data);
          2'd1:    m_amp[i_cfg_ch]   = int'(i_cfg_data) & 255;
          2'd2:    m_wave[i_cfg_ch]  = int'(i_cfg_data) & 3;
          default: m_phase[i_cfg_ch] = int'(i_cfg_data) << 8;
        endcase
      end
      if (i_tick) begin
        if (m_bsy) m_ovr = 1'b1;
        else begin
          last_tick = cyc;
          for (int k = 0; k < N; k++) begin
            exp_t e;
            m_phase[k] = (m_phase[k] + m_freq[k]) & 32'hFF_FFFF;
            e.due = cyc + 2 + k;
            e.ch = k;
            e.sample = model_sample(m_wave[k], m_phase[k] >> 16, m_amp[k]);
            q.push_back(e);
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking_en) begin
      bit exp_v;
      while (q.size() > 0 && q[0].due < cyc) begin
        check("missing_valid", 0, 1);
        void'(q.pop_front());
      end
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("o_valid", o_valid, exp_v);
      if (exp_v && o_valid === 1'b1) begin
        check("o_ch", o_ch, q[0].ch);
        check("o_sample", $signed(o_sample), q[0].sample);
        void'(q.pop_front());
      end
      if (o_valid === 1'b1) begin
        got_sample[o_ch] = int'($signed(o_sample));
        got_cnt++;
      end
      check("o_busy", o_busy, busy_at(cyc));
      check("o_cfg_ready", o_cfg_ready, !busy_at(cyc));
      check("o_overrun", o_overrun, m_ovr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic tick, input logic cv, input int ch,
                       input logic [1:0] sel, input logic [15:0] data);
    i_tick = tick; i_cfg_valid = cv; i_cfg_ch = 2'(ch);
    i_cfg_sel = sel; i_cfg_data = data;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 2'd0, 16'h0);
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] sel, input logic [15:0] data);
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      done = o_cfg_ready;
      drive(1'b0, 1'b1, ch, sel, data);
    end
    if (!done) check("cfg_write_timeout", 0, 1);
    idle(1);
  endtask

  task automatic do_tick();
    drive(1'b1, 1'b0, 0, 2'd0, 16'h0);
    idle(N + 1);
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc;

    // Model pins: hand-computed expectations.
    check("pin_saw_top", model_sample(2, 8'hFF, 255), 126);
    check("pin_saw_bot", model_sample(2, 8'h00, 255), -128);
    check("pin_tri_7f",  model_sample(1, 8'h7F, 255), 125);
    check("pin_tri_c0",  model_sample(1, 8'hC0, 255), -2);
    check("pin_sq_lo",   model_sample(0, 8'h00, 100), 49);
    check("pin_sq_hi",   model_sample(0, 8'h80, 100), -50);

    repeat (2) @(posedge clk); #1;
    i_reset = 1'b0;
    checking_en = 1'b1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_ch", o_ch, 0);
    check("rst_o_sample", o_sample, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_o_overrun", o_overrun, 0);
    check("rst_o_cfg_ready", o_cfg_ready, 1);

    // First sweep after reset: four zero samples.
    base = got_cnt;
    do_tick();
    check("first_sweep_cnt", got_cnt - base, 4);
    check("first_sweep_ch3", got_sample[3], 0);

    // Sawtooth on ch0 running through a full phase wrap.
    cfg_write(0, CFG_WAVE, 16'(SAWTOOTH));
    cfg_write(0, CFG_AMP, 16'd255);
    cfg_write(0, CFG_FREQ, 16'hFFFF);
    repeat (256) do_tick();
    check("saw_tick256", got_sample[0], 126);
    do_tick();
    check("saw_tick257", got_sample[0], -128);

    // Triangle on ch1 with frozen phase.
    cfg_write(1, CFG_WAVE, 16'(TRIANGLE));
    cfg_write(1, CFG_AMP, 16'd255);
    cfg_write(1, CFG_SYNC, 16'h4000); do_tick();
    check("tri_4000", got_sample[1], 0);
    cfg_write(1, CFG_SYNC, 16'h7F00); do_tick();
    check("tri_7f00", got_sample[1], 125);
    cfg_write(1, CFG_SYNC, 16'hC000); do_tick();
    check("tri_c000", got_sample[1], -2);

    // Square on ch2, then silence it with amp 0.
    cfg_write(2, CFG_WAVE, 16'(SQUARE));
    cfg_write(2, CFG_AMP, 16'd100);
    cfg_write(2, CFG_SYNC, 16'h0000); do_tick();
    check("sq_0000", got_sample[2], 49);
    cfg_write(2, CFG_SYNC, 16'h8000); do_tick();
    check("sq_8000", got_sample[2], -50);
    cfg_write(2, CFG_AMP, 16'd0); do_tick();
    check("sq_amp0", got_sample[2], 0);

    // Overrun and config stall: tick at T and T+2, config held from T+1.
    base = got_cnt;
    acc = -1;
    drive(1'b1, 1'b0, 0, 2'd0, 16'h0);
    for (int k = 1; k <= 20 && acc < 0; k++) begin
      if (o_cfg_ready) acc = k;
      drive(k == 2, 1'b1, 3, CFG_AMP, 16'd77);
    end
    idle(N + 2);
    check("cfg_accept_cycle", acc, 6);
    check("overrun_set", o_overrun, 1);
    check("overrun_pulses", got_cnt - base, 4);
    do_tick();
    check("stalled_write_amp", got_sample[3], model_sample(0, 0, 77));

    // Reset in T+3 of a sweep aborts it.
    drive(1'b1, 1'b0, 0, 2'd0, 16'h0);
    drive(1'b0, 1'b0, 0, 2'd0, 16'h0);
    drive(1'b0, 1'b0, 0, 2'd0, 16'h0);
    base = got_cnt;
    i_reset = 1'b1;
    drive(1'b0, 1'b0, 0, 2'd0, 16'h0);
    i_reset = 1'b0;
    idle(N + 2);
    check("abort_pulses", got_cnt - base, 1);
    check("abort_overrun", o_overrun, 0);
    base = got_cnt;
    do_tick();
    check("post_rst_cnt", got_cnt - base, 4);
    check("post_rst_ch0", got_sample[0], 0);
    check("post_rst_ch3", got_sample[3], 0);

    // Random traffic: ticks, config writes (stalled or not), occasional reset.
    for (int k = 0; k < 1500; k++) begin
      i_reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 6) == 0, $urandom_range(0, 2) == 0,
            int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom));
    end
    i_reset = 1'b0;
    idle(N + 4);
    check("final_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfo_bank.md
# lfo_bank

- Multi-channel, time-multiplexed low-frequency oscillator bank for the synth modulation path.
- Holds N_CH independent phase accumulators, each with its own frequency, amplitude and wave type (square, triangle, sawtooth, reverse sawtooth).
- On each sample tick it sweeps all channels, one per clock, and emits an amplitude-scaled signed sample per channel.
- Sits between the control-register decoder (config writes) and the modulation mixer (sample stream).

## Interface
- N_CH, 4: number of channels; must be ≥ 2.
- PHASE_W, 24: phase accumulator width.
- FREQ_W, 16: frequency word / config data width; must be ≤ PHASE_W.
- OUT_W, 8: waveform, amplitude and sample width; must be ≤ FREQ_W.
- CH_W, $clog2(N_CH): derived channel index width.
- i_clock  in  1  system clock (25 MHz).
- i_reset  in  1  reset i_reset, synchronous, active-high.
- i_tick  in  1  one-cycle strobe that starts a sweep.
- i_cfg_valid  in  1  config write request.
- o_cfg_ready  out  1  config write accepted when valid & ready.
- i_cfg_ch  in  CH_W  target channel.
- i_cfg_sel  in  2  0 freq, 1 amp, 2 wave, 3 phase sync.
- i_cfg_data  in  FREQ_W  write data.
- o_valid  out  1  sample strobe.
- o_ch  out  CH_W  channel of o_sample.
- o_sample  out  OUT_W  signed scaled sample.
- o_busy  out  1  sweep or pipeline active.
- o_overrun  out  1  sticky: tick arrived while busy.

## Operation
- Per-channel state:
  - phase, PHASE_W bits, reset 0.
  - freq, FREQ_W bits, reset 0.
  - amp, OUT_W unsigned, reset 0.
  - wave, 2 bits, reset SQUARE.
- Config writes:
  - freq <= data.
  - amp <= data[OUT_W-1:0].
  - wave <= data[1:0].
  - phase sync sets phase <= {data, (PHASE_W-FREQ_W) zeros}.
  - o_cfg_ready = !o_busy; a write is accepted only when valid & ready.
- FSM has two states, IDLE and SWEEP.
  - IDLE → SWEEP on i_tick.
  - In SWEEP, channel counter c steps 0..N_CH-1, one channel per cycle; after c = N_CH-1 the FSM returns to IDLE.
- Stage 1 for channel c:
  - phase[c] <= phase[c] + freq[c], zero-extended, wrapping mod 2^PHASE_W.
  - The waveform is computed from t = top OUT_W bits of the updated phase; M = 2^(OUT_W-1).
  - SAWTOOTH: raw = t − M.
  - REVERSE_SAWTOOTH: raw = ~(t − M).
  - SQUARE: raw = M−1 when t MSB is 0, else −M.
  - TRIANGLE: f = t MSB ? ~t[OUT_W-2:0] : t[OUT_W-2:0]; raw = {f,0} − M.
- Stage 2 (registered output):
  - o_sample = (raw × signed{0,amp}) >>> OUT_W, arithmetic shift, floor, then take the low OUT_W bits.
  - The result never overflows.
- Boundary conditions:
  - freq 0 holds phase, so the output is constant.
  - amp 0 gives o_sample 0.
  - i_tick while o_busy is ignored and sets o_overrun, which is cleared only by reset.
  - i_tick in the same cycle as an accepted config write: the write commits at that edge and the sweep uses the new value.
  - Reset mid-sweep aborts the sweep: no further o_valid; all state and outputs return to reset values.

## Timing
- Reset values: o_valid 0, o_ch 0, o_sample 0, o_busy 0, o_overrun 0, o_cfg_ready 1.
- With i_tick sampled at edge T:
  - Channel k is processed in cycle T+1+k.
  - o_valid/o_ch = k/o_sample are high in cycle T+2+k, one cycle each.
  - o_busy is high from T+1 through T+N_CH+1.
- Minimum tick spacing is N_CH+2 cycles.
- Config write latency is 1 cycle.

## Structure
- Package lfo_pkg holds:
  - The wave enum: SQUARE 2'b00, TRIANGLE 2'b01, SAWTOOTH 2'b10, REVERSE_SAWTOOTH 2'b11.
  - The cfg_sel constants: CFG_FREQ 0, CFG_AMP 1, CFG_WAVE 2, CFG_SYNC 3.
- Sub-module lfo_shaper: combinational (t, wave) → raw, parameterised by OUT_W.
- Per-channel state is held in register arrays in lfo_bank.

## Test plan
All tests use the defaults N_CH 4, PHASE_W 24, FREQ_W 16, OUT_W 8.
- Reset, then tick at T → o_valid in T+2..T+5 with o_ch 0,1,2,3, all samples 0; o_busy T+1..T+5.
- ch0 SAWTOOTH, amp 255, freq 0xFFFF:
  - Ticks 1..256 reach phase 0xFFFF00 (t 0xFF), sample 126.
  - Tick 257 wraps to phase 0x00FEFF, sample −128.
- ch1 TRIANGLE, amp 255, freq 0:
  - Sync 0x4000 → 0.
  - Sync 0x7F00 → 125.
  - Sync 0xC000 → −2.
- ch2 SQUARE, amp 100, freq 0:
  - Sync 0x0000 → 49.
  - Sync 0x8000 → −50.
  - Set amp 0 → 0.
- Overrun and config stall:
  - Tick at T and at T+2 → only 4 o_valid pulses, o_overrun = 1.
  - cfg_valid held from T+1 → o_cfg_ready 0 until T+6; the write is accepted at T+6.
- Reset asserted in T+3 of a sweep → no o_valid from T+4; outputs and channel state return to reset values; o_overrun 0.
